// File: rtl/ucaspian_axon_pkg.sv
// Shared types for the axon stage: config entry layout and FSM states.
package ucaspian_axon_pkg;

  localparam int unsigned AXON_DW     = 4;
  localparam int unsigned AXON_SYN_AW = 12;
  localparam int unsigned AXON_SYN_CW = 8;

  typedef struct packed {
    logic [AXON_DW-1:0]     delay;
    logic [AXON_SYN_AW-1:0] syn_start;
    logic [AXON_SYN_CW-1:0] syn_count;
  } axon_cfg_t;

  typedef enum logic [2:0] {
    StIdle,
    StClrAct,
    StClrCfg,
    StScan,
    StDrain
  } axon_state_e;

  // Last synapse of a range; wraps modulo the synapse address space.
  function automatic logic [AXON_SYN_AW-1:0] range_end(input logic [AXON_SYN_AW-1:0] start,
                                                       input logic [AXON_SYN_CW-1:0] count);
    return start + AXON_SYN_AW'(count) - AXON_SYN_AW'(1);
  endfunction

endpackage

// File: rtl/ucaspian_axon_fifo.sv
// Valid/ready output FIFO holding {syn_start, syn_end} ranges; DEPTH must be a power of two.
module ucaspian_axon_fifo #(
  parameter int unsigned  DEPTH = 4,
  parameter int unsigned  WIDTH = 24,
  localparam int unsigned PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_rdy,
  output logic [PW:0]      used
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      cnt_q;
  logic             push, pop;

  assign pop      = out_vld && out_rdy;
  assign push     = in_vld && ((cnt_q != (PW+1)'(DEPTH)) || pop);
  assign out_vld  = cnt_q != '0;
  assign out_data = mem[rd_ptr_q];
  assign used     = cnt_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/ucaspian_axon_pq.sv
// Axon stage: per-axon delay shift queues and synapse-range lookup feeding an output FIFO.
// Optional AXON_FIRE_COUNT_EN adds a saturating per-step push counter on fire_count.
module ucaspian_axon_pq
  import ucaspian_axon_pkg::*;
#(
  parameter int unsigned  N_AXONS   = 256,
  parameter int unsigned  MAX_DELAY = 15,
  parameter int unsigned  SYN_AW    = AXON_SYN_AW,
  parameter int unsigned  SYN_CW    = AXON_SYN_CW,
  parameter int unsigned  OUT_DEPTH = 4,
  localparam int unsigned AW        = $clog2(N_AXONS),
  localparam int unsigned DW        = $clog2(MAX_DELAY + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear_act,
  input  logic              clear_config,
  output logic              clear_done,
  input  logic [AW-1:0]     config_addr,
  input  logic [DW-1:0]     config_delay,
  input  logic [SYN_AW-1:0] config_syn_start,
  input  logic [SYN_CW-1:0] config_syn_count,
  input  logic              config_enable,
  input  logic              next_step,
  output logic              step_done,
  input  logic [AW-1:0]     axon_addr,
  input  logic              axon_vld,
  output logic              axon_rdy,
  output logic [SYN_AW-1:0] syn_start,
  output logic [SYN_AW-1:0] syn_end,
  output logic              syn_vld,
  input  logic              syn_rdy
`ifdef AXON_FIRE_COUNT_EN
  ,
  output logic [15:0]       fire_count
`endif
);

  localparam int unsigned   QW       = MAX_DELAY + 1;
  localparam int unsigned   PW       = $clog2(OUT_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_AXONS - 1);

  axon_state_e   state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          clr_done_q, clr_done_d;
  logic          step_done_q, step_done_d;

  logic [QW-1:0] dly_ram [N_AXONS];
  axon_cfg_t     cfg_ram [N_AXONS];

  logic          in_clear, clr_pending, room, fire_acc, scan_go, rd_en, shifted;
  logic [AW-1:0] rd_addr;
  logic [PW:0]   fifo_used;
  logic [PW+1:0] occupancy;

  logic          dly_we, cfg_we, clr_act_we, clr_cfg_we;
  logic [AW-1:0] dly_waddr, cfg_waddr;
  logic [QW-1:0] dly_wdata, dly_rd_q;
  axon_cfg_t     cfg_wdata, cfg_rd_q;

  logic          s1_vld_q, s1_fire_q, s1_shifted_q;
  logic [AW-1:0] s1_addr_q;
  logic          s2_vld_q, s2_fire_q, s2_shifted_q;
  logic [AW-1:0] s2_addr_q;
  logic [QW-1:0] s2_q_q, s2_q_d, s2_wdata;
  axon_cfg_t     s2_cfg_q;
  logic          s2_we, s2_emit;
  logic [DW-1:0] bit_sel;

  logic                  push;
  logic [2*SYN_AW-1:0]   push_data, fifo_out;

  assign in_clear    = state_q inside {StClrAct, StClrCfg};
  assign clr_pending = (state_q == StIdle) && (clear_act || clear_config) && !next_step;
  assign occupancy   = (PW+2)'(fifo_used) + (PW+2)'(s1_vld_q) + (PW+2)'(s2_vld_q);
  assign room        = occupancy <= (PW+2)'(OUT_DEPTH - 3);
  assign axon_rdy    = reset && room && !in_clear && !clr_pending;
  assign fire_acc    = axon_vld && axon_rdy;
  assign scan_go     = (state_q == StScan) && enable && !fire_acc && room;
  assign rd_en       = fire_acc || scan_go;
  assign rd_addr     = fire_acc ? axon_addr : idx_q;
  // The scan has already visited this axon in the current step.
  assign shifted     = (state_q == StDrain) || (state_q == StIdle) || (idx_q > axon_addr);

  assign clr_act_we = (state_q == StClrAct) && !clr_done_q;
  assign clr_cfg_we = (state_q == StClrCfg) && !clr_done_q;

  always_comb begin
    dly_we    = 1'b0;
    dly_waddr = s2_addr_q;
    dly_wdata = s2_wdata;
    if (clr_act_we) begin
      dly_we    = 1'b1;
      dly_waddr = idx_q;
      dly_wdata = '0;
    end else if (s2_vld_q && s2_we) begin
      dly_we = 1'b1;
    end
  end

  always_comb begin
    cfg_we    = clr_cfg_we || (config_enable && !in_clear);
    cfg_waddr = clr_cfg_we ? idx_q : config_addr;
    cfg_wdata = '{delay: config_delay, syn_start: config_syn_start, syn_count: config_syn_count};
    if (clr_cfg_we) cfg_wdata = '0;
  end

  // Reads are write-first so an entry written this cycle is seen by the read issued alongside it.
  always_ff @(posedge clk) begin
    if (dly_we) dly_ram[dly_waddr] <= dly_wdata;
    if (cfg_we) cfg_ram[cfg_waddr] <= cfg_wdata;
    if (rd_en) begin
      dly_rd_q <= (dly_we && (dly_waddr == rd_addr)) ? dly_wdata : dly_ram[rd_addr];
      cfg_rd_q <= (cfg_we && (cfg_waddr == rd_addr)) ? cfg_wdata : cfg_ram[rd_addr];
    end
  end

  always_comb begin
    s2_we    = 1'b0;
    s2_emit  = 1'b0;
    s2_wdata = s2_q_q;
    bit_sel  = s2_cfg_q.delay;
    if (s2_fire_q) begin
      if (s2_cfg_q.delay == '0) begin
        s2_emit = 1'b1;
      end else begin
        s2_we    = 1'b1;
        bit_sel  = s2_shifted_q ? (s2_cfg_q.delay - 1'b1) : s2_cfg_q.delay;
        s2_wdata = s2_q_q | (QW'(1) << bit_sel);
      end
    end else begin
      s2_we    = 1'b1;
      s2_emit  = s2_q_q[0];
      s2_wdata = s2_q_q >> 1;
    end
    if (s2_cfg_q.syn_count == '0) s2_emit = 1'b0;
  end

  assign s2_q_d = (s2_vld_q && s2_we && (s2_addr_q == s1_addr_q)) ? s2_wdata : dly_rd_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= rd_en;
      s2_vld_q <= s1_vld_q;
    end
  end

  always_ff @(posedge clk) begin
    s1_fire_q    <= fire_acc;
    s1_addr_q    <= rd_addr;
    s1_shifted_q <= shifted;
    s2_fire_q    <= s1_fire_q;
    s2_addr_q    <= s1_addr_q;
    s2_shifted_q <= s1_shifted_q;
    s2_q_q       <= s2_q_d;
    s2_cfg_q     <= cfg_rd_q;
  end

  assign push      = s2_vld_q && s2_emit;
  assign push_data = {s2_cfg_q.syn_start, range_end(s2_cfg_q.syn_start, s2_cfg_q.syn_count)};

  ucaspian_axon_fifo #(
    .DEPTH (OUT_DEPTH),
    .WIDTH (2 * SYN_AW)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (push),
    .in_data  (push_data),
    .out_vld  (syn_vld),
    .out_data (fifo_out),
    .out_rdy  (syn_rdy),
    .used     (fifo_used)
  );

  assign syn_start = fifo_out[2*SYN_AW-1:SYN_AW];
  assign syn_end   = fifo_out[SYN_AW-1:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    clr_done_d  = clr_done_q;
    step_done_d = step_done_q;
    unique case (state_q)
      StIdle: begin
        // Sweeps start only once the pipeline has drained so its writes never collide.
        if (!s1_vld_q && !s2_vld_q) begin
          if (clear_act) begin
            state_d    = StClrAct;
            idx_d      = '0;
            clr_done_d = 1'b0;
          end else if (clear_config) begin
            state_d    = StClrCfg;
            idx_d      = '0;
            clr_done_d = 1'b0;
          end
        end
      end
      StClrAct, StClrCfg: begin
        if (!clr_done_q) begin
          if (idx_q == LAST_IDX) begin
            clr_done_d = 1'b1;
            idx_d      = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else if ((state_q == StClrAct) ? !clear_act : !clear_config) begin
          state_d    = StIdle;
          clr_done_d = 1'b0;
        end
      end
      StScan: begin
        if (!enable) begin
          idx_d = '0;
        end else if (scan_go) begin
          if (idx_q == LAST_IDX) begin
            idx_d   = '0;
            state_d = StDrain;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StDrain: begin
        if (enable && !s1_vld_q && !s2_vld_q && !syn_vld) begin
          step_done_d = 1'b1;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (next_step) begin
      state_d     = StScan;
      idx_d       = '0;
      clr_done_d  = 1'b0;
      step_done_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      clr_done_q  <= 1'b0;
      step_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      clr_done_q  <= clr_done_d;
      step_done_q <= step_done_d;
    end
  end

  assign clear_done = clr_done_q;
  assign step_done  = step_done_q;

`ifdef AXON_FIRE_COUNT_EN
  logic [15:0] fire_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      fire_count_q <= '0;
    end else if (next_step) begin
      fire_count_q <= '0;
    end else if (push && !step_done_q && (fire_count_q != 16'hFFFF)) begin
      fire_count_q <= fire_count_q + 1'b1;
    end
  end

  assign fire_count = fire_count_q;
`endif

endmodule

// File: tb/tb_ucaspian_axon_pq.sv
// Directed self-checking bench for ucaspian_axon_pq (default parameters).
module tb_ucaspian_axon_pq;

  logic        clk = 1'b0;
  logic        reset, enable, clear_act, clear_config, clear_done;
  logic [7:0]  config_addr;
  logic [3:0]  config_delay;
  logic [11:0] config_syn_start;
  logic [7:0]  config_syn_count;
  logic        config_enable, next_step, step_done;
  logic [7:0]  axon_addr;
  logic        axon_vld, axon_rdy;
  logic [11:0] syn_start, syn_end;
  logic        syn_vld, syn_rdy;
`ifdef AXON_FIRE_COUNT_EN
  logic [15:0] fire_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [23:0] rx [$];

  always #5 clk = ~clk;

  ucaspian_axon_pq dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .clear_act        (clear_act),
    .clear_config     (clear_config),
    .clear_done       (clear_done),
    .config_addr      (config_addr),
    .config_delay     (config_delay),
    .config_syn_start (config_syn_start),
    .config_syn_count (config_syn_count),
    .config_enable    (config_enable),
    .next_step        (next_step),
    .step_done        (step_done),
    .axon_addr        (axon_addr),
    .axon_vld         (axon_vld),
    .axon_rdy         (axon_rdy),
    .syn_start        (syn_start),
    .syn_end          (syn_end),
    .syn_vld          (syn_vld),
    .syn_rdy          (syn_rdy)
`ifdef AXON_FIRE_COUNT_EN
    ,
    .fire_count       (fire_count)
`endif
  );

  // Record every delivered range in handshake order.
  always @(posedge clk) begin
    if (reset && syn_vld && syn_rdy) rx.push_back({syn_start, syn_end});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg(input int a, input int d, input int start, input int count);
    config_addr      = 8'(a);
    config_delay     = 4'(d);
    config_syn_start = 12'(start);
    config_syn_count = 8'(count);
    config_enable    = 1'b1;
    tick(1);
    config_enable    = 1'b0;
  endtask

  // Returns just after the handshake edge.
  task automatic fire(input int a);
    int n = 0;
    axon_addr = 8'(a);
    axon_vld  = 1'b1;
    while (!axon_rdy && n < 300) begin
      tick(1);
      n++;
    end
    chk("fire_rdy_wait", 32'(n < 300), 1);
    tick(1);
    axon_vld = 1'b0;
  endtask

  task automatic do_clear(input bit act);
    int n = 0;
    if (act) clear_act = 1'b1;
    else     clear_config = 1'b1;
    while (!clear_done && n < 600) begin
      tick(1);
      n++;
    end
    chk(act ? "clr_act_done" : "clr_cfg_done", 32'(clear_done), 1);
    chk("clr_axon_rdy", 32'(axon_rdy), 0);
    clear_act    = 1'b0;
    clear_config = 1'b0;
    tick(1);
    chk("clr_done_drop", 32'(clear_done), 0);
  endtask

  task automatic start_step();
    next_step = 1'b1;
    tick(1);
    next_step = 1'b0;
    chk("step_done_cleared", 32'(step_done), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!step_done && n < 3000) begin
      tick(1);
      n++;
    end
    chk("step_done_seen", 32'(step_done), 1);
  endtask

  initial begin
    reset            = 1'b0;
    enable           = 1'b1;
    clear_act        = 1'b0;
    clear_config     = 1'b0;
    config_addr      = '0;
    config_delay     = '0;
    config_syn_start = '0;
    config_syn_count = '0;
    config_enable    = 1'b0;
    next_step        = 1'b0;
    axon_addr        = '0;
    axon_vld         = 1'b0;
    syn_rdy          = 1'b1;
    tick(3);
    chk("rst_syn_vld", 32'(syn_vld), 0);
    chk("rst_step_done", 32'(step_done), 0);
    chk("rst_clear_done", 32'(clear_done), 0);
    chk("rst_axon_rdy", 32'(axon_rdy), 0);
    reset = 1'b1;
    tick(1);
    chk("idle_axon_rdy", 32'(axon_rdy), 1);

    do_clear(1'b0);
    do_clear(1'b1);

    // d=0 fire: range appears three cycles after the handshake and holds under backpressure.
    cfg(3, 0, 100, 4);
    rx.delete();
    syn_rdy = 1'b0;
    fire(3);
    chk("lat_c1_vld", 32'(syn_vld), 0);
    tick(1);
    chk("lat_c2_vld", 32'(syn_vld), 0);
    tick(1);
    chk("lat_c3_vld", 32'(syn_vld), 1);
    chk("lat_start", 32'(syn_start), 100);
    chk("lat_end", 32'(syn_end), 103);
    tick(1);
    chk("hold_vld", 32'(syn_vld), 1);
    chk("hold_start", 32'(syn_start), 100);
    syn_rdy = 1'b1;
    tick(1);
    chk("pop_vld", 32'(syn_vld), 0);
    chk("lat_rx_count", 32'(rx.size()), 1);

    // count=0 emits nothing; start=4095,count=2 wraps to end 0.
    cfg(7, 0, 50, 0);
    rx.delete();
    fire(7);
    tick(6);
    chk("cnt0_rx", 32'(rx.size()), 0);
    chk("cnt0_vld", 32'(syn_vld), 0);
    cfg(9, 0, 4095, 2);
    fire(9);
    tick(6);
    chk("wrap_rx_count", 32'(rx.size()), 1);
    if (rx.size() > 0) chk("wrap_range", 32'(rx[0]), 32'({12'd4095, 12'd0}));

    // d=2 fired while idle: silent in step 1, delivered in step 2.
    cfg(5, 2, 8, 1);
    rx.delete();
    fire(5);
    start_step();
    wait_done();
    chk("dly_step1_rx", 32'(rx.size()), 0);
    tick(5);
    chk("step_done_held", 32'(step_done), 1);
    start_step();
    wait_done();
    chk("dly_step2_rx", 32'(rx.size()), 1);
    if (rx.size() > 0) chk("dly_step2_range", 32'(rx[0]), 32'({12'd8, 12'd8}));

    // d=2 fired after the scan passed axon 5: delivered two steps later.
    rx.delete();
    start_step();
    tick(40);
    fire(5);
    wait_done();
    chk("late_step3_rx", 32'(rx.size()), 0);
    start_step();
    wait_done();
    chk("late_step4_rx", 32'(rx.size()), 0);
    start_step();
    wait_done();
    chk("late_step5_rx", 32'(rx.size()), 1);
    if (rx.size() > 0) chk("late_step5_range", 32'(rx[0]), 32'({12'd8, 12'd8}));

    // Backpressure: syn_rdy low for 50 cycles while fires are pending.
    for (int i = 0; i < 8; i++) cfg(20 + i, 0, 320 + 16 * i, 3);
    rx.delete();
    syn_rdy = 1'b0;
    fire(20);
    fire(21);
    tick(4);
    chk("bp_axon_rdy_low", 32'(axon_rdy), 0);
    begin
      int rdy_seen = 0;
      axon_addr = 8'd22;
      axon_vld  = 1'b1;
      repeat (50) begin
        tick(1);
        if (axon_rdy) rdy_seen++;
      end
      chk("bp_rdy_cycles", 32'(rdy_seen), 0);
    end
    chk("bp_vld_held", 32'(syn_vld), 1);
    chk("bp_head_start", 32'(syn_start), 320);
    chk("bp_rx_none", 32'(rx.size()), 0);
    syn_rdy = 1'b1;
    for (int i = 2; i < 8; i++) fire(20 + i);
    tick(12);
    chk("bp_rx_count", 32'(rx.size()), 8);
    for (int i = 0; i < 8; i++) begin
      logic [23:0] exp_r;
      exp_r = {12'(320 + 16 * i), 12'(322 + 16 * i)};
      if (i < rx.size()) chk("bp_order", 32'(rx[i]), 32'(exp_r));
    end

    // Reset mid-scan, then clear queues: next step completes with no emits.
    start_step();
    tick(30);
    reset = 1'b0;
    tick(2);
    chk("mid_rst_syn_vld", 32'(syn_vld), 0);
    chk("mid_rst_step_done", 32'(step_done), 0);
    chk("mid_rst_clear_done", 32'(clear_done), 0);
    chk("mid_rst_axon_rdy", 32'(axon_rdy), 0);
    reset = 1'b1;
    tick(3);
    chk("post_rst_step_done", 32'(step_done), 0);
    do_clear(1'b1);
    rx.delete();
    start_step();
    wait_done();
    chk("post_clr_rx", 32'(rx.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
